// File: rtl/console_uart_tx.sv
// console_uart_tx
//   Device-side transmitter for the core's console port. Bytes written with
//   console_we are queued in a small FIFO and shifted out on tx as 8N1 UART
//   frames. With CONSOLE_TX_PARITY_EN defined, frames are 8E1 and carry an
//   even-parity bit between data bit 7 and the stop bit.
//
//   Ports:
//     clk            system clock, all state changes on posedge
//     reset_n        asynchronous active-low reset
//     console_we     one-cycle write strobe, one byte per asserted cycle
//     console_wdata  write data, only [7:0] is transmitted
//     tx             UART serial line, idles high (registered)
//     busy           FIFO non-empty or frame in flight (registered)
//     fifo_full      FIFO holds FIFO_DEPTH bytes (registered)
//     overflow       sticky: a write was dropped because the FIFO was full
//
//   Optional macro: CONSOLE_TX_PARITY_EN

module console_uart_tx #(
    parameter int XLEN       = 32,
    parameter int CLK_DIV    = 868,
    parameter int FIFO_DEPTH = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            console_we,
    input  logic [XLEN-1:0] console_wdata,
    output logic            tx,
    output logic            busy,
    output logic            fifo_full,
    output logic            overflow
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLK_DIV);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef CONSOLE_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    logic [7:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    state_t            state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shreg;

    logic baud_last;
    logic push_ok;
    logic pop;
    logic going_idle;
    logic unused_wdata;

    assign unused_wdata = ^console_wdata[XLEN-1:8];

    always_comb begin
        baud_last  = (baud_cnt == BAUD_W'(CLK_DIV - 1));
        push_ok    = console_we && (count != CNT_W'(FIFO_DEPTH));
        // The FSM takes a byte either from IDLE or straight out of the stop
        // bit, which is what makes queued frames run back to back.
        pop        = (count != '0) &&
                     ((state == S_IDLE) || ((state == S_STOP) && baud_last));
        going_idle = (count == '0) &&
                     ((state == S_IDLE) || ((state == S_STOP) && baud_last));
        count_next = count;
        case ({push_ok, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    // FIFO storage and shift register hold data only, so they carry no reset.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= console_wdata[7:0];
        if (pop)
            shreg <= mem[rd_ptr];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            state     <= S_IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            tx        <= 1'b1;
            busy      <= 1'b0;
            fifo_full <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            // Pointers wrap naturally because FIFO_DEPTH is a power of two.
            if (push_ok)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count     <= count_next;
            fifo_full <= (count_next == CNT_W'(FIFO_DEPTH));
            // A full FIFO drops the write even when a pop frees a slot this cycle.
            if (console_we && (count == CNT_W'(FIFO_DEPTH)))
                overflow <= 1'b1;
            busy <= !going_idle || (count_next != '0);

            case (state)
                S_IDLE: begin
                    tx       <= 1'b1;
                    baud_cnt <= '0;
                    if (pop) begin
                        tx    <= 1'b0;
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx       <= shreg[0];
                        state    <= S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                S_DATA: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
`ifdef CONSOLE_TX_PARITY_EN
                            tx    <= ^shreg;
                            state <= S_PARITY;
`else
                            tx    <= 1'b1;
                            state <= S_STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shreg[bit_idx + 3'd1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
`ifdef CONSOLE_TX_PARITY_EN
                S_PARITY: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        tx       <= 1'b1;
                        state    <= S_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            tx    <= 1'b0;
                            state <= S_START;
                        end else begin
                            tx    <= 1'b1;
                            state <= S_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                default: begin
                    tx       <= 1'b1;
                    baud_cnt <= '0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule
